// File: rtl/counter_load_arbiter.sv
// rtl/counter_load_arbiter.sv - round-robin arbiter sharing an up-counter load port; optional wrap_irq via CNT_LOAD_ARB_WRAP_IRQ_EN
module counter_load_arbiter #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int HOLD = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N-1:0]                  req,
  input  logic [N*W-1:0]                req_data,
  input  logic [W-1:0]                  count_in,
  output logic [N-1:0]                  gnt,
  output logic                          load,
  output logic [W-1:0]                  data,
  output logic [((N>1)?$clog2(N):1)-1:0] owner,
  output logic                          busy,
  output logic                          wrap_irq
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t         state, state_d;
  logic [IW-1:0]  ptr, ptr_d;
  logic [7:0]     hold_cnt, hold_d;
  logic [N-1:0]   gnt_d;
  logic           load_d;
  logic [W-1:0]   data_d;
  logic [IW-1:0]  owner_d;
  logic           busy_d;
  logic           found;
  logic [IW-1:0]  win;
  int             idx;

  // Next-state and next-output logic; outputs are all registered so req never reaches gnt/load combinationally
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    hold_d  = hold_cnt;
    gnt_d   = '0;
    load_d  = 1'b0;
    data_d  = data;
    owner_d = owner;
    busy_d  = busy;
    found   = 1'b0;
    win     = '0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
    case (state)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (found) begin
          state_d    = ST_LOAD;
          gnt_d[win] = 1'b1;
          load_d     = 1'b1;
          data_d     = req_data[int'(win)*W +: W];
          owner_d    = win;
          busy_d     = 1'b1;
          ptr_d      = (int'(win) == N-1) ? '0 : win + 1'b1;
        end
      end
      ST_LOAD: begin
        if (HOLD == 0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_HOLD;
          hold_d  = 8'(HOLD - 1);
          busy_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == 8'd0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          hold_d = hold_cnt - 8'd1;
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers; async reset aborts any pending load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      hold_cnt <= 8'd0;
      gnt      <= '0;
      load     <= 1'b0;
      data     <= '0;
      owner    <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      hold_cnt <= hold_d;
      gnt      <= gnt_d;
      load     <= load_d;
      data     <= data_d;
      owner    <= owner_d;
      busy     <= busy_d;
    end
  end

`ifdef CNT_LOAD_ARB_WRAP_IRQ_EN
  logic [W-1:0] count_q;
  logic         load_q;

  // Wrap detect: all-ones to zero, excluding transitions caused by our own load strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      load_q   <= 1'b0;
      wrap_irq <= 1'b0;
    end else begin
      count_q  <= count_in;
      load_q   <= load;
      wrap_irq <= (count_q == {W{1'b1}}) && (count_in == '0) && !load_q;
    end
  end
`else
  logic unused_count;
  assign unused_count = ^count_in;
  assign wrap_irq     = 1'b0;
`endif

endmodule

// File: tb/tb_counter_load_arbiter.sv
// tb/tb_counter_load_arbiter.sv - directed self-checking bench for counter_load_arbiter
module tb_counter_load_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [7:0]  count_in;
  logic [3:0]  gnt;
  logic        load;
  logic [7:0]  data;
  logic [1:0]  owner;
  logic        busy;
  logic        wrap_irq;

  int tests = 0;
  int fails = 0;

  counter_load_arbiter #(.N(4), .W(8), .HOLD(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .count_in (count_in),
    .gnt      (gnt),
    .load     (load),
    .data     (data),
    .owner    (owner),
    .busy     (busy),
    .wrap_irq (wrap_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    req      = 4'b0000;
    req_data = {8'd30, 8'd20, 8'd10, 8'd0};
    count_in = 8'd0;
    repeat (3) @(negedge clk);
    tests++;
    if ({gnt, load, data, owner, busy, wrap_irq} !== 17'd0) begin
      fails++;
      $display("FAIL reset_outputs: got gnt=%b load=%b data=%0d owner=%0d busy=%b wrap=%b expected all 0",
               gnt, load, data, owner, busy, wrap_irq);
    end
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++;
      if ({gnt, load, busy} !== 6'd0) begin
        fails++;
        $display("FAIL reset_idle: cycle %0d got gnt=%b load=%b busy=%b expected 0", i, gnt, load, busy);
      end
    end
  endtask

  task automatic test_single();
    req_data[23:16] = 8'd50;
    req = 4'b0100;
    @(negedge clk);
    tests++;
    if ({gnt, load, data, owner, busy} !== {4'b0100, 1'b1, 8'd50, 2'd2, 1'b1}) begin
      fails++;
      $display("FAIL single_grant: got gnt=%b load=%b data=%0d owner=%0d busy=%b expected 0100 1 50 2 1",
               gnt, load, data, owner, busy);
    end
    req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({gnt, load, busy, data, owner} !== {4'b0000, 1'b0, 1'b1, 8'd50, 2'd2}) begin
        fails++;
        $display("FAIL single_hold: cycle %0d got gnt=%b load=%b busy=%b data=%0d owner=%0d expected 0000 0 1 50 2",
                 i, gnt, load, busy, data, owner);
      end
    end
    @(negedge clk);
    tests++;
    if ({busy, load, data, owner} !== {1'b0, 1'b0, 8'd50, 2'd2}) begin
      fails++;
      $display("FAIL single_idle: got busy=%b load=%b data=%0d owner=%0d expected 0 0 50 2", busy, load, data, owner);
    end
  endtask

  task automatic test_round_robin();
    int g;
    int last;
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    req_data = {8'd30, 8'd20, 8'd10, 8'd0};
    req = 4'b1111;
    g = 0;
    last = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (load) begin
        exp_g = 4'b0001 << (g % 4);
        exp_d = 8'((g % 4) * 10);
        tests++;
        if ({gnt, data, owner} !== {exp_g, exp_d, 2'(g % 4)}) begin
          fails++;
          $display("FAIL rr_grant%0d: got gnt=%b data=%0d owner=%0d expected %b %0d %0d",
                   g, gnt, data, owner, exp_g, exp_d, g % 4);
        end
        if (g > 0) begin
          tests++;
          if (cyc - last !== 7) begin
            fails++;
            $display("FAIL rr_spacing%0d: got %0d cycles expected 7", g, cyc - last);
          end
        end
        last = cyc;
        g++;
        if (g == 5) begin
          req = 4'b0000;
          break;
        end
      end
    end
    tests++;
    if (g !== 5) begin
      fails++;
      $display("FAIL rr_count: got %0d grants expected 5", g);
    end
  endtask

  task automatic test_hold_block();
    req_data[15:8] = 8'd77;
    @(negedge clk);
    @(negedge clk);
    req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({gnt, load} !== 5'd0) begin
        fails++;
        $display("FAIL hold_block: cycle %0d got gnt=%b load=%b expected 0", i, gnt, load);
      end
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL hold_idle: got busy=%b expected 0", busy);
    end
    @(negedge clk);
    tests++;
    if ({gnt, load, data, owner} !== {4'b0010, 1'b1, 8'd77, 2'd1}) begin
      fails++;
      $display("FAIL hold_grant: got gnt=%b load=%b data=%0d owner=%0d expected 0010 1 77 1", gnt, load, data, owner);
    end
    req = 4'b0000;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL areset_pre: got busy=%b expected 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({gnt, load, data, owner, busy, wrap_irq} !== 17'd0) begin
      fails++;
      $display("FAIL areset_outputs: got gnt=%b load=%b data=%0d owner=%0d busy=%b wrap=%b expected all 0",
               gnt, load, data, owner, busy, wrap_irq);
    end
    @(negedge clk);
    rst = 1'b1;
    req = 4'b1000;
    @(negedge clk);
    tests++;
    if ({gnt, load, data, owner} !== {4'b1000, 1'b1, 8'd30, 2'd3}) begin
      fails++;
      $display("FAIL areset_wrap_search: got gnt=%b load=%b data=%0d owner=%0d expected 1000 1 30 3",
               gnt, load, data, owner);
    end
    req = 4'b0000;
    repeat (7) @(negedge clk);
  endtask

  task automatic test_wrap();
    do_reset();
`ifdef CNT_LOAD_ARB_WRAP_IRQ_EN
    req_data[7:0] = 8'd200;
    req = 4'b0001;
    @(negedge clk);
    tests++;
    if ({load, data} !== {1'b1, 8'd200}) begin
      fails++;
      $display("FAIL wrap_load: got load=%b data=%0d expected 1 200", load, data);
    end
    req = 4'b0000;
    for (int v = 200; v < 256; v++) begin
      @(negedge clk);
      tests++;
      if (wrap_irq !== 1'b0) begin
        fails++;
        $display("FAIL wrap_early: count %0d got wrap=%b expected 0", v, wrap_irq);
      end
      count_in = 8'(v);
    end
    @(negedge clk);
    count_in = 8'd0;
    @(negedge clk);
    tests++;
    if (wrap_irq !== 1'b1) begin
      fails++;
      $display("FAIL wrap_pulse: got wrap=%b expected 1", wrap_irq);
    end
    count_in = 8'd1;
    @(negedge clk);
    tests++;
    if (wrap_irq !== 1'b0) begin
      fails++;
      $display("FAIL wrap_width: got wrap=%b expected 0", wrap_irq);
    end
    count_in = 8'd255;
    @(negedge clk);
    @(negedge clk);
    req_data[7:0] = 8'd0;
    req = 4'b0001;
    @(negedge clk);
    tests++;
    if (load !== 1'b1) begin
      fails++;
      $display("FAIL wrap_reload: got load=%b expected 1", load);
    end
    req = 4'b0000;
    @(negedge clk);
    count_in = 8'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (wrap_irq !== 1'b0) begin
        fails++;
        $display("FAIL wrap_load_induced: cycle %0d got wrap=%b expected 0", i, wrap_irq);
      end
    end
`else
    count_in = 8'd255;
    @(negedge clk);
    @(negedge clk);
    count_in = 8'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (wrap_irq !== 1'b0) begin
        fails++;
        $display("FAIL wrap_disabled: cycle %0d got wrap=%b expected 0", i, wrap_irq);
      end
    end
`endif
  endtask

  initial begin
    rst      = 1'b0;
    req      = 4'b0000;
    req_data = 32'd0;
    count_in = 8'd0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold_block();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
